// File: rtl/mod_n_digit_counter_pkg.sv
// Shared defaults and elaboration helpers for the cascaded mod-N counter.
// Imported by the digit cell and the top-level counter.
package mod_n_digit_counter_pkg;

    localparam int BASE_DEF   = 9;
    localparam int DIGITS_DEF = 2;
    localparam int DW_DEF     = 4;

    // Bits needed to hold values 0..v-1; used only for parameter checking.
    function automatic int clog2_int(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/mod_n_digit_counter_if.sv
// Control/status bundle for mod_n_digit_counter; digit i sits at [i*DW +: DW].
// master drives the controls, slave is the counter.
interface mod_n_digit_counter_if #(
    parameter int DIGITS = 2,
    parameter int DW     = 4
);
    logic                  clr;
    logic                  ld;
    logic [DIGITS*DW-1:0]  ld_val;
    logic                  en;
    logic                  up;
    logic [DIGITS*DW-1:0]  q;
    logic                  tc;
    logic                  wrap;

    modport master (output clr, ld, ld_val, en, up, input q, tc, wrap);
    modport slave  (input clr, ld, ld_val, en, up, output q, tc, wrap);
endinterface

// File: rtl/mod_n_digit_counter_digit.sv
// One mod-BASE digit: clear > load (clamped to BASE-1) > step > hold.
// Latency one edge; no backpressure, steps whenever step is high.
module mod_n_digit
    import mod_n_digit_counter_pkg::*;
#(
    parameter int BASE = BASE_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ld,
    input  logic [DW-1:0] ld_dig,
    input  logic          step,
    input  logic          up,
    output logic [DW-1:0] dig,
    output logic          at_max,
    output logic          at_zero
);
    localparam logic [DW-1:0] MAX = DW'(BASE - 1);
    localparam logic [DW-1:0] ONE = DW'(1);

    assign at_max  = (dig == MAX);
    assign at_zero = (dig == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig <= '0;
        end else if (clr) begin
            dig <= '0;
        end else if (ld) begin
            dig <= (ld_dig > MAX) ? MAX : ld_dig;
        end else if (step) begin
            if (up) dig <= at_max  ? '0  : dig + ONE;
            else    dig <= at_zero ? MAX : dig - ONE;
        end
    end
endmodule

// File: rtl/mod_n_digit_counter.sv
// Cascaded DIGITS x mod-BASE up/down counter with load, clear, TC and WRAP.
// Q and WRAP update one edge after sampling; TC is combinational; never stalls.
module mod_n_digit_counter
    import mod_n_digit_counter_pkg::*;
#(
    parameter int BASE   = BASE_DEF,
    parameter int DIGITS = DIGITS_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mod_n_digit_counter_if.slave  bus
);
    if (clog2_int(BASE) > DW || BASE < 2) begin : g_bad_params
        $error("mod_n_digit_counter: BASE=%0d does not fit DW=%0d", BASE, DW);
    end

    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_zero;

    // Digit i steps only when every lower digit is at its carry/borrow limit.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        if (i == 0) begin : g_first
            assign step[i] = bus.en;
        end else begin : g_rest
            assign step[i] = step[i-1] & (bus.up ? at_max[i-1] : at_zero[i-1]);
        end

        mod_n_digit #(.BASE(BASE), .DW(DW)) u_dig (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (bus.clr),
            .ld      (bus.ld),
            .ld_dig  (bus.ld_val[i*DW +: DW]),
            .step    (step[i]),
            .up      (bus.up),
            .dig     (bus.q[i*DW +: DW]),
            .at_max  (at_max[i]),
            .at_zero (at_zero[i])
        );
    end

    assign bus.tc = bus.en & (bus.up ? (&at_max) : (&at_zero));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wrap <= 1'b0;
        end else if (bus.clr || bus.ld) begin
            bus.wrap <= 1'b0;
        end else begin
            bus.wrap <= bus.tc;
        end
    end
endmodule

// File: tb/tb_mod_n_digit_counter.sv
// Bench for mod_n_digit_counter (BASE=9, DIGITS=2, DW=4) against an integer model.
module tb_mod_n_digit_counter;
    import mod_n_digit_counter_pkg::*;

    localparam int BASE   = 9;
    localparam int DIGITS = 2;
    localparam int DW     = 4;
    localparam int QW     = DIGITS * DW;
    localparam int NSTATE = BASE ** DIGITS;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Model: counter as a plain integer 0..NSTATE-1, plus expected WRAP.
    int   m_val;
    bit   m_wrap;
    bit   c_clr, c_ld, c_en, c_up;
    logic [QW-1:0] c_ldv;

    mod_n_digit_counter_if #(.DIGITS(DIGITS), .DW(DW)) bus ();

    mod_n_digit_counter #(.BASE(BASE), .DIGITS(DIGITS), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [QW-1:0] to_q(input int v);
        logic [QW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*DW +: DW] = DW'(t % BASE);
            t = t / BASE;
        end
        return r;
    endfunction

    function automatic int from_ld(input logic [QW-1:0] lv);
        int v, w, d;
        v = 0;
        w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[i*DW +: DW]);
            if (d > BASE - 1) d = BASE - 1;
            v = v + d * w;
            w = w * BASE;
        end
        return v;
    endfunction

    function automatic bit model_tc(input bit e, input bit u, input int v);
        return e && (u ? (v == NSTATE - 1) : (v == 0));
    endfunction

    task automatic set_in(input bit c, input bit l, input logic [QW-1:0] lv,
                          input bit e, input bit u);
        c_clr = c; c_ld = l; c_ldv = lv; c_en = e; c_up = u;
        bus.clr = c; bus.ld = l; bus.ld_val = lv; bus.en = e; bus.up = u;
        #1;
    endtask

    // One rising edge with the current inputs; the model advances alongside.
    task automatic tick();
        bit tc_pre;
        tc_pre = model_tc(c_en, c_up, m_val);
        @(posedge clk);
        #1;
        if (c_clr) begin
            m_val = 0; m_wrap = 0;
        end else if (c_ld) begin
            m_val = from_ld(c_ldv); m_wrap = 0;
        end else begin
            m_wrap = tc_pre;
            if (c_en) m_val = c_up ? (m_val + 1) % NSTATE : (m_val + NSTATE - 1) % NSTATE;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.q !== '0) begin
            errors++; $display("FAIL reset_q got=%h exp=00", bus.q);
        end
        checks++;
        if (bus.wrap !== 1'b0) begin
            errors++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 1, 8'h35, 0, 1);
        tick();
        checks++;
        if (bus.q !== 8'h35) begin
            errors++; $display("FAIL reset_load35 got=%h exp=35", bus.q);
        end
        set_in(0, 0, '0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        m_val = 0; m_wrap = 0;
        checks++;
        if (bus.q !== 8'h00 || bus.wrap !== 1'b0 || bus.tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got q=%h wrap=%b tc=%b exp q=00 wrap=0 tc=0",
                     bus.q, bus.wrap, bus.tc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, '0, 1, 1);
        tick();
        checks++;
        if (bus.q !== 8'h01) begin
            errors++; $display("FAIL reset_first_edge got=%h exp=01", bus.q);
        end
    endtask

    task automatic test_up_sweep();
        set_in(1, 0, '0, 0, 1);
        tick();
        set_in(0, 0, '0, 1, 1);
        for (int n = 1; n <= 80; n++) begin
            tick();
            checks++;
            if (bus.q !== to_q(m_val) || bus.wrap !== m_wrap) begin
                errors++;
                $display("FAIL up_sweep_%0d got q=%h wrap=%b exp q=%h wrap=%b",
                         n, bus.q, bus.wrap, to_q(m_val), m_wrap);
            end
            if (n == 9) begin
                checks++;
                if (bus.q !== 8'h10) begin
                    errors++; $display("FAIL up_carry got=%h exp=10", bus.q);
                end
            end
        end
        checks++;
        if (bus.q !== 8'h88 || bus.tc !== 1'b1) begin
            errors++; $display("FAIL up_top got q=%h tc=%b exp q=88 tc=1", bus.q, bus.tc);
        end
        tick();
        checks++;
        if (bus.q !== 8'h00 || bus.wrap !== 1'b1) begin
            errors++; $display("FAIL up_wrap got q=%h wrap=%b exp q=00 wrap=1", bus.q, bus.wrap);
        end
        tick();
        checks++;
        if (bus.q !== 8'h01 || bus.wrap !== 1'b0) begin
            errors++; $display("FAIL up_wrap_pulse got q=%h wrap=%b exp q=01 wrap=0", bus.q, bus.wrap);
        end
    endtask

    task automatic test_down_wrap();
        set_in(1, 0, '0, 0, 0);
        tick();
        set_in(0, 0, '0, 1, 0);
        checks++;
        if (bus.tc !== 1'b1) begin
            errors++; $display("FAIL down_tc got=%b exp=1", bus.tc);
        end
        tick();
        checks++;
        if (bus.q !== 8'h88 || bus.wrap !== 1'b1) begin
            errors++; $display("FAIL down_wrap got q=%h wrap=%b exp q=88 wrap=1", bus.q, bus.wrap);
        end
        tick();
        checks++;
        if (bus.q !== 8'h87 || bus.wrap !== 1'b0) begin
            errors++; $display("FAIL down_next got q=%h wrap=%b exp q=87 wrap=0", bus.q, bus.wrap);
        end
    endtask

    task automatic test_load_hold();
        set_in(0, 1, 8'h9C, 1, 1);
        tick();
        checks++;
        if (bus.q !== 8'h88) begin
            errors++; $display("FAIL load_clamp got=%h exp=88", bus.q);
        end
        set_in(0, 0, '0, 0, 1);
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (bus.q !== 8'h88 || bus.tc !== 1'b0 || bus.wrap !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got q=%h tc=%b wrap=%b exp q=88 tc=0 wrap=0",
                         n, bus.q, bus.tc, bus.wrap);
            end
        end
    endtask

    task automatic test_priority();
        set_in(0, 1, 8'h44, 0, 1);
        tick();
        set_in(1, 1, 8'h55, 1, 1);
        tick();
        checks++;
        if (bus.q !== 8'h00) begin
            errors++; $display("FAIL prio_clr got=%h exp=00", bus.q);
        end
        set_in(0, 1, 8'h27, 1, 1);
        tick();
        checks++;
        if (bus.q !== 8'h27) begin
            errors++; $display("FAIL prio_ld got=%h exp=27", bus.q);
        end
    endtask

    task automatic test_dir_flip();
        set_in(0, 1, 8'h08, 0, 1);
        tick();
        set_in(0, 0, '0, 1, 1);
        tick();
        checks++;
        if (bus.q !== 8'h10) begin
            errors++; $display("FAIL flip_up got=%h exp=10", bus.q);
        end
        set_in(0, 0, '0, 1, 0);
        tick();
        checks++;
        if (bus.q !== 8'h08 || bus.wrap !== 1'b0) begin
            errors++; $display("FAIL flip_down got q=%h wrap=%b exp q=08 wrap=0", bus.q, bus.wrap);
        end
    endtask

    task automatic test_random();
        bit c, l, e, u;
        logic [QW-1:0] lv;
        for (int n = 0; n < 400; n++) begin
            c  = ($urandom_range(0, 99) < 3);
            l  = ($urandom_range(0, 99) < 6);
            e  = ($urandom_range(0, 99) < 85);
            u  = ($urandom_range(0, 99) < 60);
            lv = QW'($urandom);
            set_in(c, l, lv, e, u);
            checks++;
            if (bus.tc !== model_tc(e, u, m_val)) begin
                errors++;
                $display("FAIL rand_tc_%0d got=%b exp=%b", n, bus.tc, model_tc(e, u, m_val));
            end
            tick();
            checks++;
            if (bus.q !== to_q(m_val) || bus.wrap !== m_wrap) begin
                errors++;
                $display("FAIL rand_q_%0d got q=%h wrap=%b exp q=%h wrap=%b",
                         n, bus.q, bus.wrap, to_q(m_val), m_wrap);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_val  = 0;
        m_wrap = 0;
        rst_n  = 1'b0;
        set_in(0, 0, '0, 0, 1);
        #12;
        test_reset();
        test_up_sweep();
        test_down_wrap();
        test_load_hold();
        test_priority();
        test_dir_flip();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
